// File: rtl/collision_scan_if.sv
// -----------------------------------------------------------------------------
// collision_scan_if
// Groups the signals between the collision scan controller, the game FSM
// (start/done, doodle position, results) and the block table read port.
//   start, doodle_x, doodle_y  : scan request and doodle position
//   rd_en, rd_addr             : block table read request (controller drives)
//   rd_x, rd_y, rd_active      : block table read data, one cycle after rd_en
//   busy, done                 : scan status
//   hit, hit_col, hit_row      : result of the most recent scan
// Modports: slave = the controller, master = its environment.
// -----------------------------------------------------------------------------
interface collision_scan_if #(
  parameter int COORD_W = 32,
  parameter int IDX_W   = 11
);
  logic               start;
  logic [COORD_W-1:0] doodle_x;
  logic [COORD_W-1:0] doodle_y;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_addr;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               rd_active;
  logic               busy;
  logic               done;
  logic               hit;
  logic [IDX_W-1:0]   hit_col;
  logic [IDX_W-1:0]   hit_row;

  modport slave (
    input  start, doodle_x, doodle_y, rd_x, rd_y, rd_active,
    output rd_en, rd_addr, busy, done, hit, hit_col, hit_row
  );

  modport master (
    output start, doodle_x, doodle_y, rd_x, rd_y, rd_active,
    input  rd_en, rd_addr, busy, done, hit, hit_col, hit_row
  );
endinterface

// File: rtl/collision_scan_ctrl.sv
// -----------------------------------------------------------------------------
// collision_scan_ctrl
// Walks the block table one entry per cycle after an accepted start, compares
// each active block against the latched doodle position and reports the first
// hit as a column/row index.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : collision_scan_if.slave (start/doodle in, table read port,
//            busy/done/hit/hit_col/hit_row out)
// Table index = col*BIH + row; row/col are tracked by counters rather than
// derived from the address, so no divider is needed.
// -----------------------------------------------------------------------------
module collision_scan_ctrl #(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 700,
  parameter int BLOCK_WIDTH   = 40,
  parameter int BLOCK_HEIGHT  = 5,
  parameter int COORD_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  collision_scan_if.slave   bus
);

  localparam int BIW   = SCREEN_WIDTH / BLOCK_WIDTH;
  localparam int BIH   = SCREEN_HEIGHT / BLOCK_HEIGHT;
  localparam int COUNT = BIW * BIH;
  localparam int IDX_W = $clog2(COUNT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(BIH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [IDX_W-1:0]   r_addr;
  logic [IDX_W-1:0]   r_row;
  logic [IDX_W-1:0]   r_col;
  logic               r_vld_p1;
  logic [IDX_W-1:0]   r_row_p1;
  logic [IDX_W-1:0]   r_col_p1;
  logic [COORD_W-1:0] r_dx;
  logic [COORD_W-1:0] r_dy;
  logic               r_hit;
  logic [IDX_W-1:0]   r_hit_col;
  logic [IDX_W-1:0]   r_hit_row;

  logic               w_accept;
  logic               w_cmp_vld;
  logic               w_match;
  logic               w_rd_en;
  logic               w_busy;
  logic               w_done;

  // Horizontal span check done one bit wider so a block near the top of the
  // coordinate range cannot wrap its right edge back to a small value.
  function automatic logic f_block_hit(
    input logic               act,
    input logic [COORD_W-1:0] bx,
    input logic [COORD_W-1:0] by,
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy
  );
    logic [COORD_W:0] right;
    right = {1'b0, bx} + (COORD_W+1)'(BLOCK_WIDTH);
    return act && (by == dy) && (bx <= dx) && ({1'b0, dx} <= right);
  endfunction

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  // Read data is only meaningful the cycle after a real read was issued.
  assign w_cmp_vld = r_vld_p1 && ((r_state == S_SCAN) || (r_state == S_DRAIN));
  assign w_match   = w_cmp_vld &&
                     f_block_hit(bus.rd_active, bus.rd_x, bus.rd_y, r_dx, r_dy);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SCAN;
      S_SCAN: begin
        if (w_match)               w_next = S_DONE;
        else if (r_addr == LAST_IDX) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic; the read stops in the same cycle a hit is seen.
  always_comb begin
    w_rd_en = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE:  ;
      S_SCAN:  begin w_rd_en = ~w_match; w_busy = 1'b1; end
      S_DRAIN: w_busy = 1'b1;
      S_DONE:  begin w_busy = 1'b1; w_done = 1'b1; end
      default: ;
    endcase
  end

  // Stage p0: address and row/col counters for the read being issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_accept) begin
      r_addr <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if ((r_state == S_SCAN) && (r_addr != LAST_IDX)) begin
      r_addr <= r_addr + 1'b1;
      if (r_row == LAST_ROW) begin
        r_row <= '0;
        r_col <= r_col + 1'b1;
      end else begin
        r_row <= r_row + 1'b1;
      end
    end
  end

  // Stage p1: valid and row/col aligned with returned read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= w_rd_en;
  end

  always_ff @(posedge clk) begin
    r_row_p1 <= r_row;
    r_col_p1 <= r_col;
    if (w_accept) begin
      r_dx <= bus.doodle_x;
      r_dy <= bus.doodle_y;
    end
  end

  // Result capture: cleared on accepted start, set only by the first match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit     <= 1'b0;
      r_hit_col <= '0;
      r_hit_row <= '0;
    end else if (w_accept) begin
      r_hit     <= 1'b0;
      r_hit_col <= '0;
      r_hit_row <= '0;
    end else if (w_match) begin
      r_hit     <= 1'b1;
      r_hit_col <= r_col_p1;
      r_hit_row <= r_row_p1;
    end
  end

  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = r_addr;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.hit     = r_hit;
  assign bus.hit_col = r_hit_col;
  assign bus.hit_row = r_hit_row;

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_collision_scan_ctrl
// Scoreboard bench: each accepted start pushes the result predicted by a
// reference scan of the table array; a monitor pops and compares on done.
// Cycle c = the clock period in which start is held high is cycle 0.
// -----------------------------------------------------------------------------
module tb_collision_scan_ctrl;

  localparam int COUNT = 1400;
  localparam int BIH   = 140;
  localparam int BW    = 40;
  localparam int IDX_W = 11;
  localparam int CW    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  collision_scan_if #(.COORD_W(CW), .IDX_W(IDX_W)) bus();

  collision_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic hit;
    int   col;
    int   row;
    int   done_cyc;
  } exp_t;

  logic [CW-1:0] mem_x [COUNT];
  logic [CW-1:0] mem_y [COUNT];
  logic          mem_a [COUNT];

  exp_t          q[$];
  int            cyc    = 0;
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [CW-1:0] cur_dx = '0;
  logic [CW-1:0] cur_dy = '0;
  logic          last_hit = 1'b0;
  int            last_col = 0;
  int            last_row = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Block table with a registered read port. When no read is issued the
  // port is loaded with an entry that would match the doodle, so any
  // comparison of stale data shows up as a false hit.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_x      <= mem_x[bus.rd_addr];
      bus.rd_y      <= mem_y[bus.rd_addr];
      bus.rd_active <= mem_a[bus.rd_addr];
    end else begin
      bus.rd_x      <= cur_dx;
      bus.rd_y      <= cur_dy;
      bus.rd_active <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: first table index whose block covers the doodle.
  function automatic exp_t model(input logic [CW-1:0] dx, input logic [CW-1:0] dy,
                                 input int t0);
    exp_t e;
    e.hit = 1'b0; e.col = 0; e.row = 0; e.done_cyc = t0 + COUNT + 2;
    for (int i = 0; i < COUNT; i++) begin
      if (mem_a[i] && (mem_y[i] == dy) && (longint'(mem_x[i]) <= longint'(dx)) &&
          (longint'(dx) <= longint'(mem_x[i]) + BW)) begin
        e.hit = 1'b1; e.col = i / BIH; e.row = i % BIH; e.done_cyc = t0 + i + 3;
        break;
      end
    end
    return e;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < COUNT; i++) begin
      mem_x[i] = '0; mem_y[i] = '0; mem_a[i] = 1'b0;
    end
  endtask

  task automatic put(input int idx, input logic [CW-1:0] x, input logic [CW-1:0] y);
    mem_x[idx] = x; mem_y[idx] = y; mem_a[idx] = 1'b1;
  endtask

  task automatic run_scan(input logic [CW-1:0] dx, input logic [CW-1:0] dy,
                          input bit scramble);
    exp_t e;
    @(negedge clk);
    chk("hit_held", bus.hit, last_hit);
    chk("hit_col_held", bus.hit_col, last_col);
    chk("hit_row_held", bus.hit_row, last_row);
    bus.start = 1'b1; bus.doodle_x = dx; bus.doodle_y = dy;
    cur_dx = dx; cur_dy = dy;
    e = model(dx, dy, cyc);
    q.push_back(e);
    last_hit = e.hit; last_col = e.col; last_row = e.row;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("hit_cleared", bus.hit, 0);
    if (scramble) begin
      bus.doodle_x = $urandom; bus.doodle_y = $urandom;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done, required done within 3000 cycles");
      q.delete();
    end
  endtask

  // Monitor: address sequence while reading, scoreboard compare on done.
  initial begin : monitor
    logic prev_en;
    int   exp_addr;
    exp_t e;
    prev_en = 1'b0; exp_addr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        prev_en = 1'b0;
      end else begin
        if (bus.rd_en) begin
          if (!prev_en) exp_addr = 0;
          chk("rd_addr", bus.rd_addr, exp_addr);
          exp_addr++;
        end
        prev_en = bus.rd_en;
        if (bus.done) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("hit", bus.hit, e.hit);
            chk("hit_col", bus.hit_col, e.col);
            chk("hit_row", bus.hit_row, e.row);
            chk("rd_en_at_done", bus.rd_en, 0);
            chk("busy_at_done", bus.busy, 1);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int t0;
    int j;
    bus.start = 1'b0; bus.doodle_x = '0; bus.doodle_y = '0;
    clear_mem();

    // Reset state
    #1;
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_hit_col", bus.hit_col, 0);
    chk("rst_hit_row", bus.hit_row, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty table: full walk, no hit
    run_scan(120, 50, 0); wait_idle();

    // Hit on the first entry
    put(0, 100, 50);
    run_scan(120, 50, 0); wait_idle();

    // Two matches: the lower index wins
    clear_mem(); put(283, 100, 50); put(500, 100, 50);
    run_scan(130, 50, 0); wait_idle();

    // Horizontal/vertical boundaries
    clear_mem(); put(0, 100, 50);
    run_scan(140, 50, 0); wait_idle();
    run_scan(141, 50, 0); wait_idle();
    run_scan(99, 50, 0);  wait_idle();
    run_scan(120, 51, 0); wait_idle();
    run_scan(100, 50, 0); wait_idle();

    // Right edge beyond the coordinate range must not wrap
    clear_mem(); put(7, 32'hFFFF_FFF0, 3);
    run_scan(32'hFFFF_FFFF, 3, 1); wait_idle();

    // Only the final entry matches: resolved in the drain cycle
    clear_mem(); put(COUNT-1, 100, 50);
    run_scan(100, 50, 0); wait_idle();

    // Start while busy is ignored; reset mid-scan aborts without done
    clear_mem();
    run_scan(10, 10, 0);
    t0 = cyc - 1;
    while (cyc < t0 + 200) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_rd_addr", bus.rd_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_hit = 1'b0; last_col = 0; last_row = 0;
    put(777, 200, 60);
    run_scan(215, 60, 0); wait_idle();

    // Randomized tables and doodle positions
    for (int it = 0; it < 8; it++) begin
      clear_mem();
      for (int i = 0; i < COUNT; i++) begin
        if ($urandom_range(0, 15) == 0)
          put(i, $urandom_range(0, 360), $urandom_range(0, 20));
      end
      j = $urandom_range(0, COUNT-1);
      if (it % 3 == 2)
        run_scan($urandom_range(0, 399), $urandom_range(0, 20), 1);
      else begin
        put(j, $urandom_range(0, 360), $urandom_range(0, 20));
        run_scan(mem_x[j] + $urandom_range(0, BW), mem_y[j], 1);
      end
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
